// File: rtl/riscv_isa_pkg.sv
// RV32I opcode constants, command encodings and materializer FSM states.
// Shared by the encoder and the instruction materializer.
package riscv_isa_pkg;

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;

  localparam logic [31:0] NOP_WORD = 32'h00000013;

  localparam logic [2:0] CMD_LOAD_CONST = 3'd0;
  localparam logic [2:0] CMD_JAL        = 3'd1;
  localparam logic [2:0] CMD_BRANCH     = 3'd2;
  localparam logic [2:0] CMD_STORE      = 3'd3;

  typedef enum logic [1:0] {
    S_IDLE,
    S_EMIT,
    S_EMIT_LO,
    S_ERR
  } state_e;

  typedef enum logic [2:0] {
    FMT_U,
    FMT_I,
    FMT_S,
    FMT_B,
    FMT_J
  } fmt_e;

  function automatic logic in_range(
    input logic [31:0] v,
    input int          lo,
    input int          hi
  );
    return ($signed(v) >= lo) && ($signed(v) <= hi);
  endfunction

endpackage

// File: rtl/immediate_encoder.sv
// Packs an immediate and register fields into an RV32I U/I/S/B/J word.
// Purely combinational; B and J layouts discard immediate bit 0.
module immediate_encoder
  import riscv_isa_pkg::*;
(
  input  fmt_e        fmt_i,
  input  logic [31:0] imm_i,
  input  logic [4:0]  rd_i,
  input  logic [4:0]  rs1_i,
  input  logic [4:0]  rs2_i,
  input  logic [2:0]  funct3_i,
  input  logic [6:0]  opcode_i,
  output logic [31:0] word_o
);

  always_comb begin
    word_o = '0;
    unique case (fmt_i)
      FMT_U: word_o = {imm_i[31:12], rd_i, opcode_i};
      FMT_I: word_o = {imm_i[11:0], rs1_i, funct3_i,
                       rd_i, opcode_i};
      FMT_S: word_o = {imm_i[11:5], rs2_i, rs1_i,
                       funct3_i, imm_i[4:0], opcode_i};
      FMT_B: word_o = {imm_i[12], imm_i[10:5], rs2_i,
                       rs1_i, funct3_i, imm_i[4:1],
                       imm_i[11], opcode_i};
      FMT_J: word_o = {imm_i[20], imm_i[10:1], imm_i[11],
                       imm_i[19:12], rd_i, opcode_i};
      default: word_o = '0;
    endcase
  end

endmodule

// File: rtl/instruction_materializer.sv
// Turns a command into one or two RV32I words on a valid/ready stream.
// LOAD_CONST may need a LUI/ADDI pair; bad commands pulse cmd_error.
module instruction_materializer
  import riscv_isa_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [2:0]  cmd_op,
  input  logic [4:0]  cmd_rd,
  input  logic [4:0]  cmd_rs1,
  input  logic [4:0]  cmd_rs2,
  input  logic [2:0]  cmd_funct3,
  input  logic [31:0] cmd_value,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instr_data,
  output logic        instr_last,
  output logic        cmd_error
);

  state_e      state_q, state_d;
  logic [31:0] data_q, data_d;
  logic        last_q, last_d;
  logic [31:0] lo_q, lo_d;

  logic [19:0] hi;
  logic [11:0] lo12;
  logic [31:0] lo_sext;

  fmt_e        fmt0;
  logic [31:0] imm0;
  logic [4:0]  rd0, rs1_0, rs2_0;
  logic [2:0]  f3_0;
  logic [6:0]  opc0;
  logic        use_nop, two_words, bad;
  logic [31:0] enc0_word, enc1_word, word0;

  logic is_lc, is_jal, is_br, is_st, is_ill;

  // ADDI adds a signed 12-bit lo, so hi absorbs its borrow
  assign lo12    = cmd_value[11:0];
  assign lo_sext = {{20{lo12[11]}}, lo12};
  assign hi      = cmd_value[31:12] + {19'd0, cmd_value[11]};

  assign is_lc  = cmd_op == CMD_LOAD_CONST;
  assign is_jal = cmd_op == CMD_JAL;
  assign is_br  = cmd_op == CMD_BRANCH;
  assign is_st  = cmd_op == CMD_STORE;
  assign is_ill = cmd_op[2];

  always_comb begin
    fmt0      = FMT_I;
    imm0      = '0;
    rd0       = '0;
    rs1_0     = '0;
    rs2_0     = '0;
    f3_0      = '0;
    opc0      = OP_IMM;
    use_nop   = 1'b0;
    two_words = 1'b0;
    bad       = 1'b0;
    unique case (1'b1)
      is_lc: begin
        rd0 = cmd_rd;
        if (cmd_rd == 5'd0) begin
          use_nop = 1'b1;
        end else if (hi == 20'd0) begin
          imm0 = lo_sext;
        end else begin
          fmt0      = FMT_U;
          opc0      = OP_LUI;
          imm0      = {hi, 12'd0};
          two_words = lo12 != 12'd0;
        end
      end
      is_jal: begin
        fmt0 = FMT_J;
        opc0 = OP_JAL;
        imm0 = cmd_value;
        rd0  = cmd_rd;
        bad  = cmd_value[0] ||
               !in_range(cmd_value, -(1 << 20),
                         (1 << 20) - 2);
      end
      is_br: begin
        fmt0  = FMT_B;
        opc0  = OP_BRANCH;
        imm0  = cmd_value;
        rs1_0 = cmd_rs1;
        rs2_0 = cmd_rs2;
        f3_0  = cmd_funct3;
        bad   = cmd_value[0] ||
                !in_range(cmd_value, -4096, 4094) ||
                cmd_funct3 == 3'd2 ||
                cmd_funct3 == 3'd3;
      end
      is_st: begin
        fmt0  = FMT_S;
        opc0  = OP_STORE;
        imm0  = cmd_value;
        rs1_0 = cmd_rs1;
        rs2_0 = cmd_rs2;
        f3_0  = cmd_funct3;
        bad   = !in_range(cmd_value, -2048, 2047) ||
                cmd_funct3 > 3'd2;
      end
      default: bad = 1'b1;
    endcase
    if (is_ill) bad = 1'b1;
  end

  immediate_encoder u_enc0 (
    .fmt_i    (fmt0),
    .imm_i    (imm0),
    .rd_i     (rd0),
    .rs1_i    (rs1_0),
    .rs2_i    (rs2_0),
    .funct3_i (f3_0),
    .opcode_i (opc0),
    .word_o   (enc0_word)
  );

  immediate_encoder u_enc1 (
    .fmt_i    (FMT_I),
    .imm_i    (lo_sext),
    .rd_i     (cmd_rd),
    .rs1_i    (cmd_rd),
    .rs2_i    (5'd0),
    .funct3_i (3'd0),
    .opcode_i (OP_IMM),
    .word_o   (enc1_word)
  );

  assign word0 = use_nop ? NOP_WORD : enc0_word;

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    last_d  = last_q;
    lo_d    = lo_q;
    unique case (state_q)
      S_IDLE: begin
        if (cmd_valid) begin
          if (bad) begin
            state_d = S_ERR;
          end else begin
            state_d = S_EMIT;
            data_d  = word0;
            last_d  = !two_words;
            lo_d    = enc1_word;
          end
        end
      end
      S_EMIT: begin
        if (instr_ready) begin
          if (last_q) begin
            state_d = S_IDLE;
          end else begin
            state_d = S_EMIT_LO;
            data_d  = lo_q;
            last_d  = 1'b1;
          end
        end
      end
      S_EMIT_LO: begin
        if (instr_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      data_q  <= '0;
      last_q  <= 1'b0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      last_q  <= last_d;
      lo_q    <= lo_d;
    end
  end

  assign cmd_ready   = state_q == S_IDLE;
  assign instr_valid = (state_q == S_EMIT) ||
                       (state_q == S_EMIT_LO);
  assign cmd_error   = state_q == S_ERR;
  assign instr_data  = data_q;
  assign instr_last  = last_q;

endmodule

// File: tb/tb_instruction_materializer.sv
// Random and directed stimulus for instruction_materializer,
// checked against an arithmetic model of the RV32I encodings.
module tb_instruction_materializer;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [2:0]  cmd_op;
  logic [4:0]  cmd_rd, cmd_rs1, cmd_rs2;
  logic [2:0]  cmd_funct3;
  logic [31:0] cmd_value;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr_data;
  logic        instr_last;
  logic        cmd_error;

  int checks = 0;
  int errors = 0;
  logic [31:0] obs [2];

  always #5 clk = ~clk;

  instruction_materializer dut (
    .clk         (clk),
    .rst         (rst),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_op      (cmd_op),
    .cmd_rd      (cmd_rd),
    .cmd_rs1     (cmd_rs1),
    .cmd_rs2     (cmd_rs2),
    .cmd_funct3  (cmd_funct3),
    .cmd_value   (cmd_value),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .instr_data  (instr_data),
    .instr_last  (instr_last),
    .cmd_error   (cmd_error)
  );

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] addi(input longint rd,
                                       input longint rs1,
                                       input longint imm);
    return 32'(((imm & 'hFFF) << 20) | (rs1 << 15) |
               (rd << 7) | 'h13);
  endfunction

  // Expected words straight from the ISA rules
  function automatic void model(
    input  logic [2:0]  op,
    input  logic [4:0]  rd, rs1, rs2,
    input  logic [2:0]  f3,
    input  logic [31:0] v,
    output int          n,
    output logic [31:0] w0,
    output logic [31:0] w1,
    output bit          err
  );
    longint sv, u, lo, hi, d, s1, s2, f;
    sv = longint'($signed(v));
    d = longint'(rd); s1 = longint'(rs1);
    s2 = longint'(rs2); f = longint'(f3);
    n = 1; w0 = '0; w1 = '0; err = 0;
    case (op)
      3'd0: begin
        lo = ((longint'(v) & 'hFFF) ^ 'h800) - 'h800;
        hi = ((longint'(v) - lo) >> 12) & 'hFFFFF;
        if (rd == 0) w0 = 32'h00000013;
        else if (hi == 0) w0 = addi(d, 0, lo);
        else if (lo == 0) w0 = 32'((hi << 12) | (d << 7) | 'h37);
        else begin
          n = 2;
          w0 = 32'((hi << 12) | (d << 7) | 'h37);
          w1 = addi(d, d, lo);
        end
      end
      3'd1: begin
        err = (sv % 2 != 0) || sv < -(64'sd1 << 20) ||
              sv > (64'sd1 << 20) - 2;
        u = sv & 'h1FFFFF;
        w0 = 32'((((u >> 20) & 1) << 31) |
                 (((u >> 1) & 'h3FF) << 21) |
                 (((u >> 11) & 1) << 20) |
                 (((u >> 12) & 'hFF) << 12) |
                 (d << 7) | 'h6F);
      end
      3'd2: begin
        err = (sv % 2 != 0) || sv < -4096 || sv > 4094 ||
              f3 == 2 || f3 == 3;
        u = sv & 'h1FFF;
        w0 = 32'((((u >> 12) & 1) << 31) |
                 (((u >> 5) & 'h3F) << 25) |
                 (s2 << 20) | (s1 << 15) | (f << 12) |
                 (((u >> 1) & 'hF) << 8) |
                 (((u >> 11) & 1) << 7) | 'h63);
      end
      3'd3: begin
        err = sv < -2048 || sv > 2047 || f3 > 2;
        u = sv & 'hFFF;
        w0 = 32'(((u >> 5) << 25) | (s2 << 20) |
                 (s1 << 15) | (f << 12) |
                 ((u & 'h1F) << 7) | 'h23);
      end
      default: err = 1;
    endcase
    if (err) n = 0;
  endfunction

  // stall < 0 picks a random stall per word
  task automatic run_cmd(input logic [2:0]  op,
                         input logic [4:0]  rd, rs1, rs2,
                         input logic [2:0]  f3,
                         input logic [31:0] v,
                         input int          stall);
    int n, k;
    logic [31:0] w [2];
    bit err;
    model(op, rd, rs1, rs2, f3, v, n, w[0], w[1], err);
    chk("ready_idle", 32'(cmd_ready), 1);
    cmd_op = op; cmd_rd = rd; cmd_rs1 = rs1;
    cmd_rs2 = rs2; cmd_funct3 = f3; cmd_value = v;
    cmd_valid = 1'b1;
    step();
    cmd_valid = 1'b0;
    cmd_value = $urandom;
    if (err) begin
      chk("err_pulse", 32'(cmd_error), 1);
      chk("err_novalid", 32'(instr_valid), 0);
      chk("err_busy", 32'(cmd_ready), 0);
      step();
      chk("err_clear", 32'(cmd_error), 0);
      chk("err_ready", 32'(cmd_ready), 1);
      chk("err_novalid2", 32'(instr_valid), 0);
      return;
    end
    for (int i = 0; i < n; i++) begin
      k = (stall >= 0) ? stall : int'($urandom_range(0, 2));
      instr_ready = 1'b0;
      repeat (k) begin
        chk("stall_valid", 32'(instr_valid), 1);
        chk("stall_data", instr_data, w[i]);
        chk("stall_last", 32'(instr_last), 32'(i == n - 1));
        chk("stall_busy", 32'(cmd_ready), 0);
        step();
      end
      instr_ready = 1'b1;
      chk("word_valid", 32'(instr_valid), 1);
      chk("word_data", instr_data, w[i]);
      chk("word_last", 32'(instr_last), 32'(i == n - 1));
      chk("word_noerr", 32'(cmd_error), 0);
      obs[i] = instr_data;
      step();
      instr_ready = 1'b0;
    end
    chk("done_novalid", 32'(instr_valid), 0);
    chk("done_ready", 32'(cmd_ready), 1);
  endtask

  function automatic logic [31:0] pick_value();
    logic [31:0] bnd [16];
    logic [31:0] r;
    bnd = '{-4096, 4094, 4096, -4098, -2048, 2047, 2048,
            -2049, -(1 << 20), (1 << 20) - 2, 1 << 20,
            -(1 << 20) - 2, 32'h800, 32'hFFFFF800, 0, 3};
    r = $urandom;
    case ($urandom_range(0, 3))
      0: return r;
      1: return 32'($urandom_range(0, 8191)) - 32'd4096;
      2: return bnd[$urandom_range(0, 15)];
      default: return {{11{r[20]}}, r[20:1], 1'b0};
    endcase
  endfunction

  initial begin
    logic [2:0] op;
    rst = 1'b1; cmd_valid = 1'b0; instr_ready = 1'b0;
    cmd_op = '0; cmd_rd = '0; cmd_rs1 = '0; cmd_rs2 = '0;
    cmd_funct3 = '0; cmd_value = '0;
    step(); step();
    rst = 1'b0;
    chk("rst_ready", 32'(cmd_ready), 1);
    chk("rst_valid", 32'(instr_valid), 0);
    chk("rst_data", instr_data, 0);
    chk("rst_last", 32'(instr_last), 0);
    chk("rst_error", 32'(cmd_error), 0);

    run_cmd(3'd0, 5'd5, 5'd0, 5'd0, 3'd0, 32'h12345678, 0);
    chk("lc_pair_hi", obs[0], 32'h123452B7);
    chk("lc_pair_lo", obs[1], 32'h67828293);
    run_cmd(3'd0, 5'd1, 5'd0, 5'd0, 3'd0, 32'hDEADBEEF, 3);
    chk("lc_stall_hi", obs[0], 32'hDEADC0B7);
    chk("lc_stall_lo", obs[1], 32'hEEF08093);
    run_cmd(3'd0, 5'd10, 5'd0, 5'd0, 3'd0, 32'hFFFFF800, 0);
    chk("lc_addi_only", obs[0], 32'h80000513);
    run_cmd(3'd0, 5'd0, 5'd0, 5'd0, 3'd0, 32'hFFFFF800, 0);
    chk("lc_nop", obs[0], 32'h00000013);
    run_cmd(3'd1, 5'd1, 5'd0, 5'd0, 3'd0, 32'h00000800, 0);
    chk("jal", obs[0], 32'h001000EF);
    run_cmd(3'd2, 5'd0, 5'd2, 5'd3, 3'd1, 32'hFFFFFFFC, 0);
    chk("branch", obs[0], 32'hFE311EE3);
    run_cmd(3'd1, 5'd1, 5'd0, 5'd0, 3'd0, 32'd3, 0);
    run_cmd(3'd2, 5'd0, 5'd2, 5'd3, 3'd0, 32'd4096, 0);
    run_cmd(3'd3, 5'd0, 5'd2, 5'd3, 3'd3, 32'd8, 0);
    run_cmd(3'd5, 5'd1, 5'd2, 5'd3, 3'd0, 32'd0, 0);

    // Reset while the LUI word is pending
    cmd_op = 3'd0; cmd_rd = 5'd7; cmd_value = 32'h12345678;
    cmd_valid = 1'b1;
    step();
    cmd_valid = 1'b0;
    chk("rp_valid", 32'(instr_valid), 1);
    chk("rp_lui", instr_data, 32'h123453B7);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("rp_drop", 32'(instr_valid), 0);
    chk("rp_ready", 32'(cmd_ready), 1);
    instr_ready = 1'b1;
    repeat (3) begin
      step();
      chk("rp_no_addi", 32'(instr_valid), 0);
    end
    instr_ready = 1'b0;

    for (int i = 0; i < 300; i++) begin
      op = 3'($urandom_range(0, 9) > 7 ? 0 : $urandom_range(0, 7));
      run_cmd(op, 5'($urandom), 5'($urandom), 5'($urandom),
              3'($urandom), pick_value(), -1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
